proc_io_bridge: RTL and testbench

- Hardware counterpart of the proc_fix I/O handshake. It serves the processor's sample requests (req_in/in) from an upstream valid/ready stream and collects processor results (out_en/io_out) into a downstream valid/ready stream.
- Sits between proc_fix and the sample source/sink, replacing file-based stimulus and capture on the synthesised path.
- proc_fix cannot be stalled, so the bridge buffers in both directions and flags underflow/overflow.

---
 rtl/proc_io_pkg.sv | 17 +
 rtl/sync_fifo.sv | 95 +++++++++
 rtl/proc_io_bridge.sv | 170 +++++++++++++++++
 tb/tb_proc_io_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_io_pkg.sv
// Shared constants for the proc_fix I/O bridge: default sample width,
// request/strobe codes driven by proc_fix, and the FIFO level width helper.
// No ports; imported by proc_io_bridge and sync_fifo.
package proc_io_pkg;

  localparam int DW_DEF = 32;

  // Codes proc_fix places on req_in / out_en. IO_IDLE means no transfer.
  localparam logic [1:0] IO_IDLE  = 2'd0;
  localparam logic [1:0] IO_PORT1 = 2'd1;

  // A level counter must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head.
// Ports: push_i/push_dat_i write side; pop_i read side (ignored when empty);
// head_dat_o/head_vld_o registered head, full_o/empty_o/level_o status.
// A push while full is accepted only if a pop frees a slot at the same edge.
module sync_fifo
  import proc_io_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DW-1:0]           push_dat_i,
  input  logic                    pop_i,
  output logic [DW-1:0]           head_dat_o,
  output logic                    head_vld_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [lvl_w(DEPTH)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [DW-1:0] head_q, head_d;
  logic          vld_q, vld_d;
  logic          full_q, full_d;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop_i && vld_q;
  assign push_ok = push_i && (!full_q || pop_ok);
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    head_d   = head_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_nxt;
    end
    lvl_d = lvl_q + LW'(push_ok) - LW'(pop_ok);
    // The head register mirrors mem[rd_ptr]. When the FIFO is (or is about
    // to become) empty, the incoming word becomes the head directly;
    // otherwise the next stored word is promoted on a pop.
    if (push_ok && ((lvl_q == '0) || (pop_ok && lvl_q == LW'(1)))) begin
      head_d = push_dat_i;
    end else if (pop_ok && lvl_q > LW'(1)) begin
      head_d = mem_q[rd_nxt];
    end
    vld_d  = (lvl_d != '0);
    full_d = (lvl_d == LW'(DEPTH));
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
      full_q   <= full_d;
    end
  end

  assign head_dat_o = head_q;
  assign head_vld_o = vld_q;
  assign full_o     = full_q;
  assign empty_o    = !vld_q;
  assign level_o    = lvl_q;

endmodule

// File: rtl/proc_io_bridge.sv
// Bridges proc_fix's non-stallable req_in/in and out_en/io_out handshake to
// upstream (s_*) and downstream (m_*) valid/ready streams.
// Ports: clk/rst; s_data/s_valid/s_ready in; proc_in, req_in to processor;
// io_out/out_en from processor; m_data/m_valid/m_ready out; sticky
// underflow/overflow flags; in_level/out_level occupancy.
module proc_io_bridge
  import proc_io_pkg::*;
#(
  parameter int         DW        = DW_DEF,
  parameter int         IN_DEPTH  = 16,
  parameter int         OUT_DEPTH = 16,
  parameter logic [1:0] PORT_ID   = IO_PORT1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DW-1:0]               s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DW-1:0]               proc_in,
  input  logic [1:0]                  req_in,
  input  logic [DW-1:0]               io_out,
  input  logic [1:0]                  out_en,
  output logic [DW-1:0]               m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        underflow,
  output logic                        overflow,
  output logic [lvl_w(IN_DEPTH)-1:0]  in_level,
  output logic [lvl_w(OUT_DEPTH)-1:0] out_level
);

  localparam int ILW = lvl_w(IN_DEPTH);
  // The head register counts toward the input capacity, so the FIFO itself
  // stops one short: head + FIFO never holds more than IN_DEPTH samples.
  localparam logic [ILW-1:0] IN_CAP = ILW'(IN_DEPTH - 1);

  // Reset asserts immediately, releases two edges later on clk.
  logic [1:0] rst_pipe_q;
  logic       rst_core;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_pipe_q <= 2'b11;
    end else begin
      rst_pipe_q <= {rst_pipe_q[0], 1'b0};
    end
  end

  assign rst_core = rst_pipe_q[1];

  // ---------------- input path ----------------
  logic [DW-1:0]  in_head_dat;
  logic           in_head_vld;
  logic           in_full;
  logic           in_empty;
  logic [ILW-1:0] in_lvl;
  logic [ILW-1:0] in_lvl_d;
  logic           in_push, in_pop;
  logic           req_hit;

  logic [DW-1:0] proc_in_q, proc_in_d;
  logic          head_vld_q, head_vld_d;
  logic          s_ready_q, s_ready_d;
  logic          underflow_q, underflow_d;

  assign req_hit = (req_in == PORT_ID);
  assign in_push = s_valid && s_ready_q;
  // Pop to refill an empty head (prefetch) or to replace a consumed one.
  // A request that finds the head empty blocks the pop for that edge.
  assign in_pop  = in_head_vld && (head_vld_q ? req_hit : !req_hit);

  sync_fifo #(
    .DW    (DW),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk        (clk),
    .rst        (rst_core),
    .push_i     (in_push),
    .push_dat_i (s_data),
    .pop_i      (in_pop),
    .head_dat_o (in_head_dat),
    .head_vld_o (in_head_vld),
    .full_o     (in_full),
    .empty_o    (in_empty),
    .level_o    (in_lvl)
  );

  always_comb begin
    proc_in_d   = proc_in_q;
    head_vld_d  = head_vld_q;
    underflow_d = underflow_q;
    in_lvl_d    = in_lvl + ILW'(in_push) - ILW'(in_pop);
    if (in_pop) begin
      proc_in_d  = in_head_dat;
      head_vld_d = 1'b1;
    end else if (req_hit && head_vld_q) begin
      // Consumed with nothing behind it: proc_in keeps the stale value.
      head_vld_d = 1'b0;
    end
    if (req_hit && !head_vld_q) begin
      underflow_d = 1'b1;
    end
    // Ready is registered from next-state occupancy; a pop while full only
    // reopens the stream from the following cycle.
    s_ready_d = !(in_full && !in_pop) && (in_lvl_d < IN_CAP);
  end

  always_ff @(posedge clk or posedge rst_core) begin
    if (rst_core) begin
      proc_in_q   <= '0;
      head_vld_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      proc_in_q   <= proc_in_d;
      head_vld_q  <= head_vld_d;
      s_ready_q   <= s_ready_d;
      underflow_q <= underflow_d;
    end
  end

  // ---------------- output path ----------------
  logic out_hit;
  logic out_full;
  logic out_empty;
  logic out_pop;
  logic overflow_q, overflow_d;

  assign out_hit = (out_en == PORT_ID);
  assign out_pop = m_ready && !out_empty;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst_core),
    .push_i     (out_hit),
    .push_dat_i (io_out),
    .pop_i      (m_ready),
    .head_dat_o (m_data),
    .head_vld_o (m_valid),
    .full_o     (out_full),
    .empty_o    (out_empty),
    .level_o    (out_level)
  );

  always_comb begin
    overflow_d = overflow_q;
    // Full with a simultaneous drain frees a slot, so the result survives.
    if (out_hit && out_full && !out_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_core) begin
    if (rst_core) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign proc_in   = proc_in_q;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;
  assign in_level  = in_lvl;

endmodule

// File: tb/tb_proc_io_bridge.sv
module tb_proc_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] proc_in;
  logic [1:0]  req_in;
  logic [31:0] io_out;
  logic [1:0]  out_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        underflow;
  logic        overflow;
  logic [4:0]  in_level;
  logic [4:0]  out_level;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_in[$];
  logic [31:0] exp_out[$];

  always #5 clk = ~clk;

  proc_io_bridge #(
    .DW        (32),
    .IN_DEPTH  (16),
    .OUT_DEPTH (16),
    .PORT_ID   (2'd1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .proc_in   (proc_in),
    .req_in    (req_in),
    .io_out    (io_out),
    .out_en    (out_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .underflow (underflow),
    .overflow  (overflow),
    .in_level  (in_level),
    .out_level (out_level)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
  endtask

  // Monitor: served requests and accepted output words pop the scoreboard.
  always @(negedge clk) begin
    if (!rst && req_in == 2'd1) begin
      if (exp_in.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL proc_in_unexpected_req: got %0h expected none", proc_in);
      end else begin
        chk("proc_in_served", proc_in, exp_in.pop_front());
      end
    end
    if (m_valid && m_ready) begin
      if (exp_out.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL m_data_unexpected: got %0h expected none", m_data);
      end else begin
        chk("m_data_seq", m_data, exp_out.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bit drained;
    rst = 1'b1; s_data = '0; s_valid = 1'b0; req_in = 2'd0;
    io_out = '0; out_en = 2'd0; m_ready = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_s_ready", s_ready, 0);
    chk("rst_proc_in", proc_in, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_level", in_level, 0);
    chk("rst_out_level", out_level, 0);
    rst = 1'b0;
    repeat (4) step();
    chk("post_rst_s_ready", s_ready, 1);

    // Test 1: 5, -3, 7 then three separated requests
    s_valid = 1'b1; s_data = 32'd5;
    step();
    v = -3; s_data = v;
    step();
    chk("t1_latency_proc_in", proc_in, 5);
    s_data = 32'd7;
    step();
    s_valid = 1'b0;
    exp_in.push_back(32'd5);
    req_in = 2'd1; step(); req_in = 2'd0; step();
    v = -3; exp_in.push_back(v);
    chk("t1_proc_in_2nd", proc_in, v);
    req_in = 2'd1; step(); req_in = 2'd0; step();
    exp_in.push_back(32'd7);
    chk("t1_proc_in_3rd", proc_in, 7);
    req_in = 2'd1; step(); req_in = 2'd0; step();
    chk("t1_underflow", underflow, 0);
    chk("t1_in_level", in_level, 0);

    // Test 2: fill 16 samples without requests
    s_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_data = i;
      step();
    end
    s_valid = 1'b0;
    chk("t2_s_ready_full", s_ready, 0);
    chk("t2_in_level", in_level, 15);
    chk("t2_head", proc_in, 1);
    exp_in.push_back(32'd1);
    req_in = 2'd1; step(); req_in = 2'd0;
    chk("t2_s_ready_reopen", s_ready, 1);
    chk("t2_in_level_after", in_level, 14);
    chk("t2_proc_in_after", proc_in, 2);

    // Test 3: 8 back-to-back requests then an underflowing 9th
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 101 + i;
      step();
    end
    s_valid = 1'b0;
    step();
    chk("t3_in_level", in_level, 7);
    req_in = 2'd1;
    for (int i = 0; i < 8; i++) begin
      exp_in.push_back(101 + i);
      step();
    end
    chk("t3_no_underflow_yet", underflow, 0);
    chk("t3_proc_in_last", proc_in, 108);
    exp_in.push_back(32'd108);
    step();
    req_in = 2'd0;
    chk("t3_underflow", underflow, 1);
    chk("t3_proc_in_hold", proc_in, 108);

    // Test 4: output stream passthrough
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: v = 32'd100;
        1: v = -200;
        default: v = 32'h7FFF_FFFF;
      endcase
      out_en = 2'd1; io_out = v; exp_out.push_back(v);
      step();
      out_en = 2'd0;
      chk("t4_m_valid_1cyc", m_valid, 1);
      chk("t4_m_data", m_data, v);
      step();
    end
    chk("t4_drained", m_valid, 0);

    // Test 5: overflow with m_ready low, then push while full with drain
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      out_en = 2'd1; io_out = 1000 + i;
      if (i < 16) exp_out.push_back(1000 + i);
      else chk("t5_no_overflow_at_16", overflow, 0);
      step();
    end
    out_en = 2'd0;
    chk("t5_overflow", overflow, 1);
    chk("t5_out_level_full", out_level, 16);
    chk("t5_m_data_head", m_data, 1000);
    out_en = 2'd1; io_out = 32'd2000; m_ready = 1'b1; exp_out.push_back(32'd2000);
    step();
    out_en = 2'd0;
    chk("t5_full_push_pop_level", out_level, 16);
    drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      if (!m_valid) drained = 1'b1;
      else step();
    end
    chk("t5_drain_done", drained, 1);
    chk("t5_out_level_empty", out_level, 0);
    m_ready = 1'b0;

    // Test 6: async reset mid-stream, then foreign codes
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 200 + i;
      out_en = 2'd1; io_out = 300 + i;
      step();
    end
    s_valid = 1'b0; out_en = 2'd0;
    step();
    chk("t6_in_half", in_level, 7);
    chk("t6_out_half", out_level, 8);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_proc_in", proc_in, 0);
    chk("t6_async_s_ready", s_ready, 0);
    chk("t6_async_m_valid", m_valid, 0);
    chk("t6_async_m_data", m_data, 0);
    chk("t6_async_underflow", underflow, 0);
    chk("t6_async_overflow", overflow, 0);
    chk("t6_async_in_level", in_level, 0);
    chk("t6_async_out_level", out_level, 0);
    exp_out.delete();
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    req_in = 2'd2; out_en = 2'd3; io_out = 32'd77;
    step();
    req_in = 2'd3; out_en = 2'd2;
    step();
    req_in = 2'd0; out_en = 2'd0;
    step();
    chk("t6_foreign_underflow", underflow, 0);
    chk("t6_foreign_out_level", out_level, 0);
    chk("t6_foreign_m_valid", m_valid, 0);
    s_valid = 1'b1; s_data = 32'd55;
    step();
    s_data = 32'd66;
    step();
    s_valid = 1'b0;
    step();
    chk("t6_head_55", proc_in, 55);
    req_in = 2'd2; step(); req_in = 2'd3; step(); req_in = 2'd0;
    chk("t6_foreign_req_proc_in", proc_in, 55);
    chk("t6_foreign_req_level", in_level, 1);
    exp_in.push_back(32'd55);
    req_in = 2'd1; step(); req_in = 2'd0;
    chk("t6_real_req_proc_in", proc_in, 66);
    step();
    chk("sb_in_leftover", exp_in.size(), 0);
    chk("sb_out_leftover", exp_out.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
